// File: rtl/dcache_mshr.sv
// Purpose: data-cache miss status holding registers, one entry per memory tag; optional block merging under DCACHE_MSHR_MERGE_EN.
// Latency: accept/merge/fill outputs are combinational (zero cycle); entry, busy_count and proto_err update at the next clock edge.
// Backpressure: none held internally; a rejected command (response 0) is simply not recorded and the controller retries.

`ifndef DCACHE_INDEX_SIZE
`define DCACHE_INDEX_SIZE 5
`endif
`ifndef DCACHE_TAG_SIZE
`define DCACHE_TAG_SIZE 8
`endif

module dcache_mshr #(
    parameter int NUM_TAGS    = 15,
    parameter int OFFSET_BITS = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alloc_valid,
    input  logic [63:0]                   alloc_addr,
    input  logic                          alloc_is_store,
    input  logic [3:0]                    Dmem2proc_response,
    input  logic [3:0]                    Dmem2proc_tag,
    output logic                          alloc_accept,
    output logic                          alloc_merged,
    output logic                          fill_valid,
    output logic [63:0]                   fill_addr,
    output logic [`DCACHE_INDEX_SIZE-1:0] fill_index,
    output logic [`DCACHE_TAG_SIZE-1:0]   fill_tag,
    output logic                          fill_is_store,
    output logic                          full,
    output logic [3:0]                    busy_count,
    output logic                          proto_err
);

    // Entry storage; tag 0 has no entry, so arrays start at 1.
    logic [NUM_TAGS:1] valid_q;
    logic [NUM_TAGS:1] store_q;
    logic [63:0]       addr_q [1:NUM_TAGS];
    logic [3:0]        cnt_q;
    logic              err_q;

    logic [NUM_TAGS:1] fill_oh;     // entry completing this cycle (valid and tag match)
    logic [NUM_TAGS:1] resp_oh;     // entry addressed by the granted tag
    logic [63:0]       fill_addr_sel;
    logic              fill_store_sel;
    logic              fill_hit;
    logic              alloc_write;
    logic              overwrite;
    logic              bad_tag_err;
    logic              inc;
    logic              dec;

    // Decode both tags to one-hot entry selects and mux out the completing entry.
    always_comb begin
        fill_oh        = '0;
        resp_oh        = '0;
        fill_addr_sel  = '0;
        fill_store_sel = 1'b0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            resp_oh[i] = (Dmem2proc_response == 4'(i));
            fill_oh[i] = (Dmem2proc_tag == 4'(i)) && valid_q[i];
            if (fill_oh[i]) begin
                fill_addr_sel  = addr_q[i];
                fill_store_sel = store_q[i];
            end
        end
    end

    assign fill_hit = |fill_oh;

`ifdef DCACHE_MSHR_MERGE_EN
    logic [NUM_TAGS:1] merge_hit;

    // An outstanding entry for the same block absorbs the miss, unless it is retiring this cycle.
    always_comb begin
        merge_hit = '0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            merge_hit[i] = valid_q[i] && !fill_oh[i] &&
                           (addr_q[i][63:OFFSET_BITS] == alloc_addr[63:OFFSET_BITS]);
        end
    end

    assign alloc_merged = alloc_valid & (|merge_hit) & ~reset;
`else
    assign alloc_merged = 1'b0;
`endif

    assign alloc_accept = alloc_valid & (Dmem2proc_response != 4'd0) & ~alloc_merged & ~reset;
    // A granted tag outside 1..NUM_TAGS has no entry to write; it is flagged as an error instead.
    assign alloc_write  = alloc_accept & (|resp_oh);
    // Reusing a live tag is a memory-side fault, except when that tag retires in the same cycle.
    assign overwrite    = alloc_write & (|(resp_oh & valid_q & ~fill_oh));
    assign bad_tag_err  = ((Dmem2proc_tag != 4'd0) & ~fill_hit) | (alloc_accept & ~(|resp_oh));
    assign inc          = alloc_write & ~overwrite;
    assign dec          = fill_hit;

    // Valid bits, occupancy counter and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 1; i <= NUM_TAGS; i++) begin
                if (alloc_write && resp_oh[i]) begin
                    valid_q[i] <= 1'b1;
                end else if (fill_oh[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            cnt_q <= cnt_q + 4'(inc) - 4'(dec);
            if (overwrite || bad_tag_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Entry payload; contents are meaningless while the valid bit is clear, so no reset.
    always_ff @(posedge clock) begin
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (alloc_write && resp_oh[i]) begin
                addr_q[i]  <= alloc_addr;
                store_q[i] <= alloc_is_store;
            end
`ifdef DCACHE_MSHR_MERGE_EN
            else if (alloc_merged && merge_hit[i]) begin
                store_q[i] <= store_q[i] | alloc_is_store;
            end
`endif
        end
    end

    assign fill_valid    = fill_hit & ~reset;
    assign fill_addr     = fill_valid ? fill_addr_sel : 64'd0;
    assign fill_is_store = fill_valid & fill_store_sel;
    assign fill_index    = fill_addr[OFFSET_BITS +: `DCACHE_INDEX_SIZE];
    assign fill_tag      = fill_addr[OFFSET_BITS + `DCACHE_INDEX_SIZE +: `DCACHE_TAG_SIZE];

    assign busy_count = reset ? 4'd0 : cnt_q;
    assign full       = ~reset & (cnt_q == 4'(NUM_TAGS));
    assign proto_err  = ~reset & err_q;

endmodule

// File: tb/tb_dcache_mshr.sv
`ifndef DCACHE_INDEX_SIZE
`define DCACHE_INDEX_SIZE 5
`endif
`ifndef DCACHE_TAG_SIZE
`define DCACHE_TAG_SIZE 8
`endif

module tb_dcache_mshr;
    localparam int OB = 3;

    logic                          clock = 1'b0;
    logic                          reset;
    logic                          alloc_valid;
    logic [63:0]                   alloc_addr;
    logic                          alloc_is_store;
    logic [3:0]                    Dmem2proc_response;
    logic [3:0]                    Dmem2proc_tag;
    logic                          alloc_accept;
    logic                          alloc_merged;
    logic                          fill_valid;
    logic [63:0]                   fill_addr;
    logic [`DCACHE_INDEX_SIZE-1:0] fill_index;
    logic [`DCACHE_TAG_SIZE-1:0]   fill_tag;
    logic                          fill_is_store;
    logic                          full;
    logic [3:0]                    busy_count;
    logic                          proto_err;

    int total = 0;
    int bad   = 0;

    dcache_mshr #(.NUM_TAGS(15), .OFFSET_BITS(OB)) dut (
        .clock              (clock),
        .reset              (reset),
        .alloc_valid        (alloc_valid),
        .alloc_addr         (alloc_addr),
        .alloc_is_store     (alloc_is_store),
        .Dmem2proc_response (Dmem2proc_response),
        .Dmem2proc_tag      (Dmem2proc_tag),
        .alloc_accept       (alloc_accept),
        .alloc_merged       (alloc_merged),
        .fill_valid         (fill_valid),
        .fill_addr          (fill_addr),
        .fill_index         (fill_index),
        .fill_tag           (fill_tag),
        .fill_is_store      (fill_is_store),
        .full               (full),
        .busy_count         (busy_count),
        .proto_err          (proto_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        av;
        logic [63:0] a;
        logic        st;
        logic [3:0]  rsp;
        logic [3:0]  tg;
        logic        e_acc;
        logic        e_mrg;
        logic        e_fv;
        logic [63:0] e_fa;
        logic        e_fs;
        logic [3:0]  e_busy;
        logic        e_full;
        logic        e_err;
    } vec_t;

    vec_t vt [11];

    function automatic vec_t mk(input logic av, input logic [63:0] a, input logic st,
                                input logic [3:0] rsp, input logic [3:0] tg,
                                input logic e_acc, input logic e_mrg, input logic e_fv,
                                input logic [63:0] e_fa, input logic e_fs,
                                input logic [3:0] e_busy, input logic e_full, input logic e_err);
        vec_t v;
        v.av = av; v.a = a; v.st = st; v.rsp = rsp; v.tg = tg;
        v.e_acc = e_acc; v.e_mrg = e_mrg; v.e_fv = e_fv; v.e_fa = e_fa; v.e_fs = e_fs;
        v.e_busy = e_busy; v.e_full = e_full; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic av, input logic [63:0] a, input logic st,
                       input logic [3:0] rsp, input logic [3:0] tg);
        alloc_valid        = av;
        alloc_addr         = a;
        alloc_is_store     = st;
        Dmem2proc_response = rsp;
        Dmem2proc_tag      = tg;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ea;

        //              av  addr        st  rsp  tag   acc mrg fv  fill_addr   fs  busy full err
        vt[0]  = mk(1'b0, 64'h0,    1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 4'd0, 1'b0, 1'b0);
        vt[1]  = mk(1'b1, 64'h1000, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 4'd0, 1'b0, 1'b0);
        vt[2]  = mk(1'b0, 64'h0,    1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 4'd1, 1'b0, 1'b0);
        vt[3]  = mk(1'b0, 64'h0,    1'b0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 64'h1000, 1'b0, 4'd1, 1'b0, 1'b0);
        vt[4]  = mk(1'b0, 64'h0,    1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 4'd0, 1'b0, 1'b0);
        vt[5]  = mk(1'b1, 64'h1238, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 4'd0, 1'b0, 1'b0);
        vt[6]  = mk(1'b1, 64'h1238, 1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 4'd0, 1'b0, 1'b0);
        vt[7]  = mk(1'b0, 64'h0,    1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, 64'h1238, 1'b1, 4'd1, 1'b0, 1'b0);
        vt[8]  = mk(1'b0, 64'h0,    1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 4'd0, 1'b0, 1'b0);
        vt[9]  = mk(1'b0, 64'h0,    1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 4'd0, 1'b0, 1'b1);
        vt[10] = mk(1'b0, 64'h0,    1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 4'd0, 1'b0, 1'b1);

        // Reset overrides same-cycle activity; outputs must be quiet while reset is high.
        reset = 1'b1;
        drv(1'b1, 64'h1000, 1'b0, 4'd1, 4'd5);
        #2;
        chk("rst accept", alloc_accept, 1'b0);
        chk("rst fill_valid", fill_valid, 1'b0);
        chk("rst fill_addr", fill_addr, 64'h0);
        tick();
        tick();
        chk("rst busy", busy_count, 4'd0);
        chk("rst full", full, 1'b0);
        chk("rst err", proto_err, 1'b0);
        reset = 1'b0;
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd0);
        #2;
        chk("post-rst busy", busy_count, 4'd0);
        chk("post-rst err", proto_err, 1'b0);
        tick();

        // Table-driven: basic alloc/fill, rejected grant, stray completion.
        for (int i = 0; i < 11; i++) begin
            drv(vt[i].av, vt[i].a, vt[i].st, vt[i].rsp, vt[i].tg);
            #2;
            ea = vt[i].e_fa;
            chk($sformatf("v%0d accept", i), alloc_accept, vt[i].e_acc);
            chk($sformatf("v%0d merged", i), alloc_merged, vt[i].e_mrg);
            chk($sformatf("v%0d fill_valid", i), fill_valid, vt[i].e_fv);
            chk($sformatf("v%0d fill_addr", i), fill_addr, vt[i].e_fa);
            chk($sformatf("v%0d fill_index", i), fill_index, ea[OB +: `DCACHE_INDEX_SIZE]);
            chk($sformatf("v%0d fill_is_store", i), fill_is_store, vt[i].e_fs);
            chk($sformatf("v%0d busy", i), busy_count, vt[i].e_busy);
            chk($sformatf("v%0d full", i), full, vt[i].e_full);
            chk($sformatf("v%0d err", i), proto_err, vt[i].e_err);
            tick();
        end

        // Fill all 15 tags, retire one, refill, then a grant while full is an error.
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            drv(1'b1, 64'(k * 64), 1'b0, 4'(k), 4'd0);
            #2;
            chk($sformatf("fill-up accept %0d", k), alloc_accept, 1'b1);
            tick();
        end
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd0);
        #2;
        chk("full set", full, 1'b1);
        chk("full busy", busy_count, 4'd15);
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd7);
        #2;
        chk("full fill_valid", fill_valid, 1'b1);
        chk("full fill_addr", fill_addr, 64'h1C0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd0);
        #2;
        chk("after fill full", full, 1'b0);
        chk("after fill busy", busy_count, 4'd14);
        drv(1'b1, 64'h9000, 1'b0, 4'd7, 4'd0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd0);
        #2;
        chk("refull", full, 1'b1);
        chk("refull err", proto_err, 1'b0);
        drv(1'b1, 64'hA000, 1'b0, 4'd3, 4'd0);
        #2;
        chk("accept while full", alloc_accept, 1'b1);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd3);
        #2;
        chk("grant-while-full err", proto_err, 1'b1);
        chk("grant-while-full busy", busy_count, 4'd15);
        chk("overwritten addr", fill_addr, 64'hA000);
        tick();

        // Same-tag allocate and complete in one cycle.
        do_reset();
        drv(1'b1, 64'h4440, 1'b0, 4'd4, 4'd0);
        tick();
        drv(1'b1, 64'h2000, 1'b0, 4'd4, 4'd4);
        #2;
        chk("same-tag accept", alloc_accept, 1'b1);
        chk("same-tag fill_valid", fill_valid, 1'b1);
        chk("same-tag old addr", fill_addr, 64'h4440);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd4);
        #2;
        chk("same-tag err", proto_err, 1'b0);
        chk("same-tag busy", busy_count, 4'd1);
        chk("same-tag new addr", fill_addr, 64'h2000);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd0);
        #2;
        chk("same-tag drained", busy_count, 4'd0);

        // Overwrite of a live tag; index/tag split of the completing address.
        do_reset();
        drv(1'b1, 64'h100, 1'b0, 4'd6, 4'd0);
        tick();
        drv(1'b1, 64'h1238, 1'b1, 4'd6, 4'd0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd6);
        #2;
        chk("overwrite err", proto_err, 1'b1);
        chk("overwrite busy", busy_count, 4'd1);
        chk("overwrite addr", fill_addr, 64'h1238);
        chk("fill_index 0x1238", fill_index, 5'h07);
        chk("fill_tag 0x1238", fill_tag, 8'h12);
        tick();

        // Reset mid-operation discards the entry; its later completion is an error.
        do_reset();
        drv(1'b1, 64'h800, 1'b0, 4'd8, 4'd0);
        tick();
        reset = 1'b1;
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd8);
        #2;
        chk("mid-rst busy", busy_count, 4'd0);
        chk("mid-rst fill_valid", fill_valid, 1'b0);
        tick();
        reset = 1'b0;
        #2;
        chk("discarded fill_valid", fill_valid, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd0);
        #2;
        chk("discarded err", proto_err, 1'b1);

        // Load miss then store miss to the same block.
        do_reset();
        drv(1'b1, 64'h3000, 1'b0, 4'd2, 4'd0);
        tick();
        drv(1'b1, 64'h3004, 1'b1, 4'd3, 4'd0);
        #2;
`ifdef DCACHE_MSHR_MERGE_EN
        chk("merge merged", alloc_merged, 1'b1);
        chk("merge accept", alloc_accept, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd2);
        #2;
        chk("merge busy", busy_count, 4'd1);
        chk("merge fill_is_store", fill_is_store, 1'b1);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd0);
        #2;
        chk("merge drained", busy_count, 4'd0);
`else
        chk("nomerge merged", alloc_merged, 1'b0);
        chk("nomerge accept", alloc_accept, 1'b1);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd2);
        #2;
        chk("nomerge busy", busy_count, 4'd2);
        chk("nomerge first store", fill_is_store, 1'b0);
        chk("nomerge first addr", fill_addr, 64'h3000);
        tick();
        drv(1'b0, 64'd0, 1'b0, 4'd0, 4'd3);
        #2;
        chk("nomerge second addr", fill_addr, 64'h3004);
        chk("nomerge second store", fill_is_store, 1'b1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
